// File: rtl/nms_pipeline_stage.sv
// Non-maxima suppression stage for the Canny edge path: directional local-maximum test on a 3x3
// magnitude window, frame-border suppression, sof/eol tagging, valid/ready flow. Optional weak/strong
// classification against lo_thr/hi_thr is built when NMS_HYSTERESIS_EN is defined.
module nms_pipeline_stage #(
  parameter int MAG_W     = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int TIE_BREAK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] p00,
  input  logic [MAG_W-1:0] p01,
  input  logic [MAG_W-1:0] p02,
  input  logic [MAG_W-1:0] p10,
  input  logic [MAG_W-1:0] p11,
  input  logic [MAG_W-1:0] p12,
  input  logic [MAG_W-1:0] p20,
  input  logic [MAG_W-1:0] p21,
  input  logic [MAG_W-1:0] p22,
  input  logic [1:0]       grad_dir,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] lo_thr,
  input  logic [MAG_W-1:0] hi_thr,
  output logic [MAG_W-1:0] edge_mag,
  output logic [1:0]       edge_class,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic f_keep(input logic [MAG_W-1:0] c,
                                  input logic [MAG_W-1:0] n1,
                                  input logic [MAG_W-1:0] n2);
    logic k;
    if (TIE_BREAK != 0) k = (c > n1) && (c >= n2);
    else                k = (c >= n1) && (c >= n2);
    return k && (c != '0);
  endfunction

  // Strong is tested first, so an inverted threshold pair degrades to strong-or-none.
  function automatic logic [1:0] f_class(input logic [MAG_W-1:0] c,
                                         input logic [MAG_W-1:0] lo,
                                         input logic [MAG_W-1:0] hi);
    if (c >= hi)      return 2'b10;
    else if (c >= lo) return 2'b01;
    else              return 2'b00;
  endfunction

  logic             w_adv;
  logic             w_xfer_in;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_border;
  logic [MAG_W-1:0] w_n1;
  logic [MAG_W-1:0] w_n2;
  logic             w_keep;
  logic [MAG_W-1:0] w_mag;
  logic [1:0]       w_cls;

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;

  logic             r_vld_p1;
  logic [MAG_W-1:0] r_ctr_p1;
  logic [MAG_W-1:0] r_n1_p1;
  logic [MAG_W-1:0] r_n2_p1;
  logic             r_sof_p1;
  logic             r_eol_p1;

  logic             r_vld_p2;
  logic [MAG_W-1:0] r_mag_p2;
  logic [1:0]       r_cls_p2;
  logic             r_sof_p2;
  logic             r_eol_p2;

  assign w_adv     = !r_vld_p2 || out_ready;
  assign in_ready  = w_adv;
  assign w_xfer_in = in_valid && w_adv;

  // An accepted sof redefines the current pixel as (0,0) whatever the counters say.
  assign w_col    = in_sof ? '0 : r_col;
  assign w_row    = in_sof ? '0 : r_row;
  assign w_border = (w_row == '0) || (w_row == ROW_LAST) ||
                    (w_col == '0) || (w_col == COL_LAST);

  always_comb begin
    w_n1 = p10;
    w_n2 = p12;
    case (grad_dir)
      2'b01:   begin w_n1 = p02; w_n2 = p20; end
      2'b10:   begin w_n1 = p01; w_n2 = p21; end
      2'b11:   begin w_n1 = p00; w_n2 = p22; end
      default: begin w_n1 = p10; w_n2 = p12; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer_in) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // ---- stage 1: centre, selected neighbours, position flags ----
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else if (w_adv) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_ctr_p1 <= w_border ? '0 : p11;
      r_n1_p1  <= w_n1;
      r_n2_p1  <= w_n2;
      r_sof_p1 <= (w_col == '0) && (w_row == '0);
      r_eol_p1 <= (w_col == COL_LAST);
    end
  end

  always_comb begin
    w_keep = f_keep(r_ctr_p1, r_n1_p1, r_n2_p1);
    w_mag  = '0;
    w_cls  = 2'b00;
    if (w_keep) begin
`ifdef NMS_HYSTERESIS_EN
      w_cls = f_class(r_ctr_p1, lo_thr, hi_thr);
      w_mag = (w_cls != 2'b00) ? r_ctr_p1 : '0;
`else
      w_cls = 2'b10;
      w_mag = r_ctr_p1;
`endif
    end
  end

`ifndef NMS_HYSTERESIS_EN
  logic w_unused_thr;
  assign w_unused_thr = ^{lo_thr, hi_thr, f_class(r_ctr_p1, r_n1_p1, r_n2_p1)};
`endif

  // ---- stage 2: keep decision, classification, output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_mag_p2 <= '0;
      r_cls_p2 <= 2'b00;
      r_sof_p2 <= 1'b0;
      r_eol_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2 <= r_vld_p1;
      r_mag_p2 <= r_vld_p1 ? w_mag : '0;
      r_cls_p2 <= r_vld_p1 ? w_cls : 2'b00;
      r_sof_p2 <= r_vld_p1 && r_sof_p1;
      r_eol_p2 <= r_vld_p1 && r_eol_p1;
    end
  end

  assign edge_mag   = r_mag_p2;
  assign edge_class = r_cls_p2;
  assign out_sof    = r_sof_p2;
  assign out_eol    = r_eol_p2;
  assign out_valid  = r_vld_p2;

endmodule

// File: tb/tb_nms_pipeline_stage.sv
// Directed bench for nms_pipeline_stage on a 4x4 frame; instance A uses TIE_BREAK=1, instance B
// TIE_BREAK=0. Expectations follow NMS_HYSTERESIS_EN when the bench is built with it.
module tb_nms_pipeline_stage;

`ifdef NMS_HYSTERESIS_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [1:0] grad_dir;
  logic       in_sof, in_valid, out_ready;
  logic [7:0] lo_thr, hi_thr;

  logic       a_in_ready, a_sof, a_eol, a_out_valid;
  logic [7:0] a_mag;
  logic [1:0] a_cls;
  logic       b_in_ready, b_sof, b_eol, b_out_valid;
  logic [7:0] b_mag;
  logic [1:0] b_cls;

  int checks = 0;
  int errors = 0;

  logic [11:0] qa[$];
  logic [11:0] qb[$];

  always #5 clk = ~clk;

  nms_pipeline_stage #(.MAG_W(8), .IMG_W(4), .IMG_H(4), .TIE_BREAK(1)) u_a (
    .clk(clk), .rst(rst),
    .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22),
    .grad_dir(grad_dir), .in_sof(in_sof), .in_valid(in_valid), .in_ready(a_in_ready),
    .lo_thr(lo_thr), .hi_thr(hi_thr),
    .edge_mag(a_mag), .edge_class(a_cls), .out_sof(a_sof), .out_eol(a_eol),
    .out_valid(a_out_valid), .out_ready(out_ready)
  );

  nms_pipeline_stage #(.MAG_W(8), .IMG_W(4), .IMG_H(4), .TIE_BREAK(0)) u_b (
    .clk(clk), .rst(rst),
    .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22),
    .grad_dir(grad_dir), .in_sof(in_sof), .in_valid(in_valid), .in_ready(b_in_ready),
    .lo_thr(lo_thr), .hi_thr(hi_thr),
    .edge_mag(b_mag), .edge_class(b_cls), .out_sof(b_sof), .out_eol(b_eol),
    .out_valid(b_out_valid), .out_ready(out_ready)
  );

  // Output log, packed {sof, eol, class, mag}
  always @(negedge clk) begin
    if (!rst && a_out_valid && out_ready) qa.push_back({a_sof, a_eol, a_cls, a_mag});
    if (!rst && b_out_valid && out_ready) qb.push_back({b_sof, b_eol, b_cls, b_mag});
  end

  task automatic set_win(input logic [7:0] c, input logic [1:0] d,
                         input logic [7:0] a, input logic [7:0] b);
    {p00, p01, p02, p10, p12, p20, p21, p22} = '0;
    p11 = c;
    grad_dir = d;
    case (d)
      2'b00: begin p10 = a; p12 = b; end
      2'b01: begin p02 = a; p20 = b; end
      2'b10: begin p01 = a; p21 = b; end
      default: begin p00 = a; p22 = b; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] c, input logic [1:0] d,
                      input logic [7:0] a, input logic [7:0] b, input logic sof);
    int w;
    set_win(c, d, a, b);
    in_sof = sof;
    in_valid = 1'b1;
    w = 0;
    while (!a_in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", a_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    qa.delete();
    qb.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_mag !== 8'd0) begin errors++; $display("FAIL reset_mag: got %0d want 0", a_mag); end
    checks++; if (a_cls !== 2'b00) begin errors++; $display("FAIL reset_class: got %b want 00", a_cls); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
    checks++; if (a_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", a_sof); end
    checks++; if (a_eol !== 1'b0) begin errors++; $display("FAIL reset_eol: got %b want 0", a_eol); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    send(8'd200, 2'b00, 8'd0, 8'd0, 1'b1);
    idle(0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid: got %b want 0", a_out_valid); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle2_valid: got %b want 1", a_out_valid); end
    checks++; if (a_sof !== 1'b1) begin errors++; $display("FAIL lat_sof: got %b want 1", a_sof); end
    checks++; if (a_mag !== 8'd0) begin errors++; $display("FAIL lat_corner_mag: got %0d want 0", a_mag); end
    idle(3);
  endtask

  // Interior positions 5,6,9,10 carry directional cases; everything else has centre 0.
  task automatic test_interior();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      case (i)
        5:  send(8'd120, 2'b00, 8'd50, 8'd80, 1'b0);
        6:  send(8'd60,  2'b10, 8'd60, 8'd10, 1'b0);
        9:  send(8'd5,   2'b11, 8'd1,  8'd1,  1'b0);
        10: send(8'd30,  2'b01, 8'd40, 8'd0,  1'b0);
        default: send(8'd0, 2'b00, 8'd0, 8'd0, i == 0);
      endcase
    end
    idle(5);
    checks++;
    if (qa.size() != 16) begin errors++; $display("FAIL interior_count: got %0d want 16", qa.size()); end
    for (int i = 0; i < 16 && i < qa.size(); i++) begin
      exp = {i == 0, (i % 4) == 3, 10'd0};
      if (i == 5) exp[9:0] = {2'b10, 8'd120};
      if (i == 9 && !HYST) exp[9:0] = {2'b10, 8'd5};
      checks++;
      if (qa[i] !== exp) begin errors++; $display("FAIL interior_px%0d: got %h want %h", i, qa[i], exp); end
    end
    exp = HYST ? {2'b00, 2'b01, 8'd60} : {2'b00, 2'b10, 8'd60};
    checks++;
    if (qb.size() < 7) begin errors++; $display("FAIL tie_b_count: got %0d want 16", qb.size()); end
    else if (qb[6] !== exp) begin errors++; $display("FAIL tie_b_px6: got %h want %h", qb[6], exp); end
  endtask

  task automatic test_border();
    logic [11:0] exp;
    logic        inner;
    do_reset();
    for (int i = 0; i < 16; i++) send(8'd200, 2'b00, 8'd0, 8'd0, i == 0);
    idle(5);
    checks++;
    if (qa.size() != 16) begin errors++; $display("FAIL border_count: got %0d want 16", qa.size()); end
    for (int i = 0; i < 16 && i < qa.size(); i++) begin
      inner = (i == 5) || (i == 6) || (i == 9) || (i == 10);
      exp = {i == 0, (i % 4) == 3, inner ? 2'b10 : 2'b00, inner ? 8'd200 : 8'd0};
      checks++;
      if (qa[i] !== exp) begin errors++; $display("FAIL border_px%0d: got %h want %h", i, qa[i], exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp;
    logic [12:0] snap;
    do_reset();
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'(10 + 10 * i), 2'b00, 8'd0, 8'd0, i == 0);
        in_valid = 1'b0;
        in_sof = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap = {a_mag, a_cls, a_sof, a_eol, a_out_valid};
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", a_out_valid); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready0: got %b want 0", a_in_ready); end
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if ({a_mag, a_cls, a_sof, a_eol, a_out_valid} !== snap) begin
            errors++; $display("FAIL bp_hold%0d: got %h want %h", k, {a_mag, a_cls, a_sof, a_eol, a_out_valid}, snap);
          end
          checks++;
          if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", k, a_in_ready); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    checks++;
    if (qa.size() != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", qa.size()); end
    for (int i = 0; i < 16 && i < qa.size(); i++) begin
      exp = {i == 0, (i % 4) == 3, 10'd0};
      case (i)
        5:  exp[9:0] = {HYST ? 2'b01 : 2'b10, 8'd60};
        6:  exp[9:0] = {HYST ? 2'b01 : 2'b10, 8'd70};
        9:  exp[9:0] = {2'b10, 8'd100};
        10: exp[9:0] = {2'b10, 8'd110};
        default: ;
      endcase
      checks++;
      if (qa[i] !== exp) begin errors++; $display("FAIL bp_px%0d: got %h want %h", i, qa[i], exp); end
    end
  endtask

  task automatic test_resync();
    logic [11:0] exp;
    int          pos;
    logic        inner;
    do_reset();
    for (int i = 0; i < 22; i++) send(8'd200, 2'b00, 8'd0, 8'd0, (i == 0) || (i == 6));
    idle(5);
    checks++;
    if (qa.size() != 22) begin errors++; $display("FAIL resync_count: got %0d want 22", qa.size()); end
    for (int i = 0; i < 22 && i < qa.size(); i++) begin
      pos = (i < 6) ? i : i - 6;
      inner = (pos == 5) || (pos == 6) || (pos == 9) || (pos == 10);
      exp = {pos == 0, (pos % 4) == 3, inner ? 2'b10 : 2'b00, inner ? 8'd200 : 8'd0};
      checks++;
      if (qa[i] !== exp) begin errors++; $display("FAIL resync_px%0d: got %h want %h", i, qa[i], exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    lo_thr = 8'd20;
    hi_thr = 8'd100;
    set_win(8'd0, 2'b00, 8'd0, 8'd0);
    test_reset();
    test_latency();
    test_interior();
    test_border();
    test_backpressure();
    test_resync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
